// File: rtl/alu_pkg.sv
// alu_pkg
//   Definitions shared by the 16-bit ALU and its result-capture stage.
//   - opcode constants (stored verbatim as tags, never decoded here)
//   - flag bit positions inside the 3-bit flag field {C, V, Z}
//   - pack_flags(): builds that field from the three individual flags
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SHL = 4'b0101;
    localparam logic [3:0] OP_SHR = 4'b0110;

    localparam int FLG_C  = 2;
    localparam int FLG_V  = 1;
    localparam int FLG_Z  = 0;
    localparam int FLAG_W = 3;

    function automatic logic [FLAG_W-1:0] pack_flags(input logic c, input logic v, input logic z);
        logic [FLAG_W-1:0] f;
        f        = '0;
        f[FLG_C] = c;
        f[FLG_V] = v;
        f[FLG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/alu_result_fifo_sat_counter.sv
// sat_counter
//   Saturating up-counter with synchronous clear.
//   Ports:
//     clk   - clock, rising edge
//     rst_n - asynchronous active-low reset, clears the count
//     clr   - synchronous clear
//     inc   - count one event; wins over clr (clr+inc gives 1)
//     q     - current count, holds at all-ones
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;
    logic [W-1:0] q_next;

    always_comb begin
        q_next = q_reg;
        if (inc) begin
            // A clear in the same cycle as an event restarts the count at 1
            if (clr) begin
                q_next = W'(1);
            end else if (q_reg != '1) begin
                q_next = q_reg + W'(1);
            end
        end else if (clr) begin
            q_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/alu_result_fifo.sv
// alu_result_fifo
//   Captures ALU results (result, opcode tag, {C,V,Z} flags) into a small
//   synchronous FIFO and presents the oldest entry over valid/ready.
//   Also keeps sticky carry/overflow status and a saturating count of
//   overflow pushes.
//   Ports:
//     clk, rst_n                 - clock / async active-low reset
//     in_valid, in_ready         - producer handshake (in_ready = not full)
//     op, result, carry,
//     overflow, zero             - entry written on a push
//     out_valid, out_ready       - consumer handshake (out_valid = not empty)
//     out_result, out_op,
//     out_flags                  - head entry, flags {C,V,Z}
//     count                      - occupancy 0..DEPTH
//     clr_status                 - sync clear of sticky flags and counter
//     sticky_carry, sticky_ovf   - OR of flags pushed since last clear
//     ovf_cnt                    - saturating count of overflow pushes
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              op,
    input  logic [WIDTH-1:0]        result,
    input  logic                    carry,
    input  logic                    overflow,
    input  logic                    zero,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_result,
    output logic [3:0]              out_op,
    output logic [FLAG_W-1:0]       out_flags,
    output logic [$clog2(DEPTH):0]  count,
    input  logic                    clr_status,
    output logic                    sticky_carry,
    output logic                    sticky_ovf,
    output logic [CNT_W-1:0]        ovf_cnt
);

    localparam int AW      = $clog2(DEPTH);
    localparam int ENTRY_W = WIDTH + 4 + FLAG_W;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [AW:0]   count_next;
    logic          sticky_carry_reg;
    logic          sticky_carry_next;
    logic          sticky_ovf_reg;
    logic          sticky_ovf_next;

    logic push;
    logic pop;

    logic [ENTRY_W-1:0]              wr_entry;
    logic [DEPTH-1:0][ENTRY_W-1:0]   mem_q;
    logic [ENTRY_W-1:0]              head;

    // Handshake outputs depend only on registered occupancy, so there is
    // no combinational path from in_valid/out_ready back to them.
    assign in_ready  = (count_reg != FULL_COUNT);
    assign out_valid = (count_reg != '0);

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    assign wr_entry = {result, op, pack_flags(carry, overflow, zero)};

    // Storage: one register per entry; all entries reset so the head reads
    // zero out of reset.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [ENTRY_W-1:0] entry_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_reg <= '0;
                end else if (push && (wr_ptr_reg == AW'(gi))) begin
                    entry_reg <= wr_entry;
                end
            end

            assign mem_q[gi] = entry_reg;
        end
    endgenerate

    // Head is always read from rd_ptr, so outputs are stable even when empty
    assign head       = mem_q[rd_ptr_reg];
    assign out_result = head[ENTRY_W-1 -: WIDTH];
    assign out_op     = head[FLAG_W +: 4];
    assign out_flags  = head[FLAG_W-1:0];

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + (AW+1)'(1);
            2'b01:   count_next = count_reg - (AW+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    // Clear first, then a push ORs its flags back in: a push in the clear
    // cycle leaves its flags set.
    always_comb begin
        sticky_carry_next = clr_status ? 1'b0 : sticky_carry_reg;
        sticky_ovf_next   = clr_status ? 1'b0 : sticky_ovf_reg;
        if (push) begin
            sticky_carry_next = sticky_carry_next | carry;
            sticky_ovf_next   = sticky_ovf_next | overflow;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            sticky_carry_reg <= 1'b0;
            sticky_ovf_reg   <= 1'b0;
        end else begin
            // DEPTH is a power of two, so natural wrap gives modulo DEPTH
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg        <= count_next;
            sticky_carry_reg <= sticky_carry_next;
            sticky_ovf_reg   <= sticky_ovf_next;
        end
    end

    assign count        = count_reg;
    assign sticky_carry = sticky_carry_reg;
    assign sticky_ovf   = sticky_ovf_reg;

    sat_counter #(
        .W (CNT_W)
    ) u_ovf_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_status),
        .inc   (push && overflow),
        .q     (ovf_cnt)
    );

endmodule

// File: tb/tb_alu_result_fifo.sv
module tb_alu_result_fifo;
    import alu_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  op = '0;
    logic [15:0] result = '0;
    logic        carry = 1'b0;
    logic        overflow = 1'b0;
    logic        zero = 1'b0;
    logic        out_ready = 1'b0;
    logic        clr_status = 1'b0;

    logic        in_ready, out_valid, sticky_carry, sticky_ovf;
    logic [15:0] out_result;
    logic [3:0]  out_op;
    logic [2:0]  out_flags;
    logic [2:0]  count;
    logic [7:0]  ovf_cnt;

    logic        in_ready2, out_valid2, sticky_carry2, sticky_ovf2;
    logic [15:0] out_result2;
    logic [3:0]  out_op2;
    logic [2:0]  out_flags2;
    logic [2:0]  count2;
    logic [1:0]  ovf_cnt2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_result_fifo #(.WIDTH(16), .DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .result(result), .carry(carry), .overflow(overflow), .zero(zero),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_op(out_op), .out_flags(out_flags), .count(count),
        .clr_status(clr_status), .sticky_carry(sticky_carry),
        .sticky_ovf(sticky_ovf), .ovf_cnt(ovf_cnt)
    );

    // Same stimulus, narrow counter to exercise saturation
    alu_result_fifo #(.WIDTH(16), .DEPTH(DEPTH), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .op(op), .result(result), .carry(carry), .overflow(overflow), .zero(zero),
        .out_valid(out_valid2), .out_ready(out_ready), .out_result(out_result2),
        .out_op(out_op2), .out_flags(out_flags2), .count(count2),
        .clr_status(clr_status), .sticky_carry(sticky_carry2),
        .sticky_ovf(sticky_ovf2), .ovf_cnt(ovf_cnt2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [15:0] r;
        logic [3:0]  o;
        logic [2:0]  f;
    } ent_t;

    ent_t m_q[$];
    bit   m_sc = 0;
    bit   m_sv = 0;
    int   m_ovf8 = 0;
    int   m_ovf2 = 0;

    always @(negedge rst_n) begin
        m_q.delete();
        m_sc = 0;
        m_sv = 0;
        m_ovf8 = 0;
        m_ovf2 = 0;
    end

    always @(posedge clk) begin
        bit   do_push;
        bit   do_pop;
        ent_t e;
        if (rst_n) begin
            do_push = in_valid && (m_q.size() < DEPTH);
            do_pop  = out_ready && (m_q.size() > 0);
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                e.r = result;
                e.o = op;
                e.f = {carry, overflow, zero};
                m_q.push_back(e);
            end
            if (clr_status) begin
                m_sc = 0; m_sv = 0; m_ovf8 = 0; m_ovf2 = 0;
            end
            if (do_push) begin
                m_sc = m_sc | carry;
                m_sv = m_sv | overflow;
                if (overflow) begin
                    if (m_ovf8 < 255) m_ovf8++;
                    if (m_ovf2 < 3) m_ovf2++;
                end
            end
        end
    end

    // Compare every cycle on the falling edge
    always @(negedge clk) begin
        chk("count", 32'(count), 32'(m_q.size()));
        chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(m_q.size() != DEPTH));
        chk("sticky_carry", 32'(sticky_carry), 32'(m_sc));
        chk("sticky_ovf", 32'(sticky_ovf), 32'(m_sv));
        chk("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf8));
        chk("ovf_cnt_w2", 32'(ovf_cnt2), 32'(m_ovf2));
        if (m_q.size() != 0) begin
            chk("out_result", 32'(out_result), 32'(m_q[0].r));
            chk("out_op", 32'(out_op), 32'(m_q[0].o));
            chk("out_flags", 32'(out_flags), 32'(m_q[0].f));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic iv, input logic [15:0] r, input logic [3:0] o,
                         input logic c, input logic v, input logic z,
                         input logic ordy, input logic clr);
        in_valid   = iv;
        result     = r;
        op         = o;
        carry      = c;
        overflow   = v;
        zero       = z;
        out_ready  = ordy;
        clr_status = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop1();
        drive(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", 32'(out_result), 32'd0);
        chk("rst_out_op", 32'(out_op), 32'd0);
        chk("rst_out_flags", 32'(out_flags), 32'd0);
        rst_n = 1'b1;
        idle();

        // Single push / pop, one-cycle latency
        drive(1'b1, 16'd15, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_result", 32'(out_result), 32'd15);
        chk("t1_op", 32'(out_op), 32'd0);
        chk("t1_count", 32'(count), 32'd1);
        pop1();
        chk("t1_pop_count", 32'(count), 32'd0);
        chk("t1_pop_valid", 32'(out_valid), 32'd0);
        pop1();   // pop on empty is ignored
        chk("t1_empty_pop", 32'(count), 32'd0);

        // Fill to DEPTH
        drive(1'b1, 16'd10, OP_SUB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'd5, OP_AND, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'd0, OP_OR, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 16'hFFFF, OP_XOR, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_full_count", 32'(count), 32'd4);
        chk("t2_full_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 16'd77, OP_SHL, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_held_count", 32'(count), 32'd4);
        chk("t2_head", 32'(out_result), 32'd10);
        // Push+pop while full: only the pop happens
        drive(1'b1, 16'd77, OP_SHL, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3_count", 32'(count), 32'd3);
        chk("t3_ready", 32'(in_ready), 32'd1);
        chk("t3_head", 32'(out_result), 32'd5);
        // Held entry now accepted alongside a pop
        drive(1'b1, 16'd77, OP_SHL, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t2_head0", 32'(out_result), 32'd0);
        chk("t2_flags0", 32'(out_flags), 32'b001);
        chk("t2_count3", 32'(count), 32'd3);
        pop1();
        chk("t2_headm1", 32'(out_result), 32'hFFFF);
        chk("t2_flagsm1", 32'(out_flags), 32'b100);
        pop1();
        chk("t2_head77", 32'(out_result), 32'd77);
        chk("t2_op77", 32'(out_op), 32'(OP_SHL));
        pop1();
        chk("t2_drained", 32'(count), 32'd0);

        // Sticky status and overflow counter (sticky_carry already 1 from 0xFFFF push)
        drive(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t4_clr_sc", 32'(sticky_carry), 32'd0);
        drive(1'b1, 16'h8000, OP_ADD, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("t4_sv", 32'(sticky_ovf), 32'd1);
        chk("t4_sc", 32'(sticky_carry), 32'd0);
        chk("t4_cnt", 32'(ovf_cnt), 32'd1);
        chk("t4_flags", 32'(out_flags), 32'b010);
        drive(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t4_clr_sv", 32'(sticky_ovf), 32'd0);
        chk("t4_clr_cnt", 32'(ovf_cnt), 32'd0);
        drive(1'b1, 16'h8000, OP_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t4_clrpush_sv", 32'(sticky_ovf), 32'd1);
        chk("t4_clrpush_cnt", 32'(ovf_cnt), 32'd1);
        chk("t4_clrpush_cnt2", 32'(ovf_cnt2), 32'd1);
        drive(1'b1, 16'h0000, OP_SUB, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t4_sc_set", 32'(sticky_carry), 32'd1);
        chk("t4_cnt_nochg", 32'(ovf_cnt), 32'd1);
        pop1();
        chk("t4_drained", 32'(count), 32'd0);

        // Five overflow pushes interleaved with pops
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'(16'h7000 + i), OP_ADD, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        chk("t5_cnt8", 32'(ovf_cnt), 32'd6);
        chk("t5_cnt2_sat", 32'(ovf_cnt2), 32'd3);
        pop1();

        // Asynchronous reset mid-cycle
        drive(1'b1, 16'd1, OP_SHR, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'd2, OP_SHR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 16'd3, OP_SHR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_pre_count", 32'(count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_sc", 32'(sticky_carry), 32'd0);
        chk("t6_sv", 32'(sticky_ovf), 32'd0);
        chk("t6_cnt", 32'(ovf_cnt), 32'd0);
        in_valid = 1'b1;      // ignored while in reset
        @(posedge clk);
        #1;
        chk("t6_ignored", 32'(count), 32'd0);
        rst_n = 1'b1;
        drive(1'b1, 16'h1234, OP_XOR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_after_count", 32'(count), 32'd1);
        chk("t6_after_result", 32'(out_result), 32'h1234);
        chk("t6_after_op", 32'(out_op), 32'(OP_XOR));
        pop1();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_result_fifo.md
# alu_result_fifo

Downstream capture stage for the 16-bit combinational `alu`. It registers each accepted ALU result, its opcode tag and its three flags into a small synchronous FIFO. It presents the oldest entry to the consumer over a valid/ready handshake. It also keeps sticky CARRY/OVERFLOW status and a saturating overflow-event counter for software.

## Interface
- `WIDTH`, 16: data width; matches the `alu` `WIDTH`.
- `DEPTH`, 4: FIFO entries; must be a power of two, ≥2.
- `CNT_W`, 8: width of the overflow-event counter.
- `CLK` input 1: single clock; all state updates on the rising edge.
- `RST_N` input 1: reset; one clock, asynchronous, active-low.
- `IN_VALID` input 1: the ALU output below is valid this cycle.
- `IN_READY` output 1: FIFO can accept; `IN_READY = (COUNT != DEPTH)`.
- `OP` input 4: opcode that produced `RESULT`; stored as a tag.
- `RESULT` input WIDTH: ALU result.
- `CARRY`, `OVERFLOW`, `ZERO` input 1 each: ALU flags.
- `OUT_VALID` output 1: head entry valid; equals `COUNT != 0`.
- `OUT_READY` input 1: consumer accepts the head entry.
- `OUT_RESULT` output WIDTH: head result.
- `OUT_OP` output 4: head opcode tag.
- `OUT_FLAGS` output 3: head flags {CARRY, OVERFLOW, ZERO}, MSB first.
- `COUNT` output $clog2(DEPTH)+1: occupancy, 0..DEPTH.
- `CLR_STATUS` input 1: synchronous clear of sticky flags and counter.
- `STICKY_CARRY`, `STICKY_OVF` output 1 each: OR of the flags of all pushed entries since the last clear or reset.
- `OVF_CNT` output CNT_W: number of pushes with OVERFLOW=1; saturates at 2^CNT_W−1.

## Operation
- Push = `IN_VALID && IN_READY`. The entry {RESULT, OP, CARRY, OVERFLOW, ZERO} is written at `wr_ptr`, and `wr_ptr` increments modulo DEPTH.
- Pop = `OUT_VALID && OUT_READY`. `rd_ptr` increments modulo DEPTH.
- `COUNT` update: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- Full (`COUNT == DEPTH`):
  - `IN_READY` = 0 and no push occurs, even if a pop happens in the same cycle.
  - There is no full-bypass; the input sees ready again on the cycle after the pop.
- Empty:
  - `OUT_VALID` = 0.
  - `OUT_*` data are don't-care but must be stable (read from `mem[rd_ptr]`).
  - A pop with `OUT_READY` = 1 is ignored.
- No fall-through: a push into an empty FIFO becomes visible on the next cycle.
- Sticky flags: on a push, `STICKY_CARRY |= CARRY` and `STICKY_OVF |= OVERFLOW`.
- `CLR_STATUS` clears the sticky flags and `OVF_CNT`. If the same cycle also has a push with a flag set, the push wins: the result is a set flag and a counter value of 1.
- `OVF_CNT` increments on a push with OVERFLOW=1 and holds at all-ones.
- `ZERO` is stored but does not feed any sticky status.
- `OP` is stored verbatim; no decoding.

## Timing
- Reset (`RST_N` low, asynchronous) forces:
  - `wr_ptr` = `rd_ptr` = 0 and `COUNT` = 0.
  - `OUT_VALID` = 0 and `IN_READY` = 1.
  - `STICKY_*` = 0 and `OVF_CNT` = 0.
  - `OUT_RESULT`, `OUT_OP`, `OUT_FLAGS` = 0 (memory entry 0 cleared).
- During reset, pushes and pops are ignored.
- Reset mid-operation discards all entries; storage contents of other entries are don't-care.
- Push at edge N: `OUT_VALID` is 1 from edge N, so the consumer samples it at edge N+1. Latency is one cycle.
- `IN_READY` and `OUT_VALID` are derived only from registered `COUNT`. There is no combinational path from `IN_VALID` or `OUT_READY` to either.
- Producer: `RESULT`, flags and `OP` must be stable across the edge where `IN_VALID && IN_READY`.
- Consumer: `OUT_*` hold until popped.

## Structure
- Shared package `alu_pkg`:
  - Opcode constants `OP_ADD`=4'b0000, `OP_SUB`=0001, `OP_AND`=0010, `OP_OR`=0011, `OP_XOR`=0100, `OP_SHL`=0101, `OP_SHR`=0110.
  - Flag indices `FLG_C`=2, `FLG_V`=1, `FLG_Z`=0, and `FLAG_W`=3.
- One sub-module is natural: `sat_counter` (parameter `W`; ports `CLK`, `RST_N`, `CLR`, `INC`, `Q`; increment takes priority over clear, giving 1; holds at max). It implements `OVF_CNT`.
- The FIFO memory is a flop array inside this block.

## Test plan
- Reset, then push RESULT=15 OP=0000 flags=000 → next cycle `OUT_VALID`=1, `OUT_RESULT`=15, `OUT_OP`=0000, `COUNT`=1; pop → `COUNT`=0, `OUT_VALID`=0.
- Push 4 entries (10, 5, 0, −1) with `OUT_READY`=0 → `COUNT`=4, `IN_READY`=0; a fifth push is held. Drain → outputs 10, 5, 0, −1 in order, then the held entry.
- At `COUNT`=4, assert push and pop together → `COUNT`=3 and `IN_READY`=1 on the next cycle; the pushed value is not stored on that edge.
- Push RESULT=−32768 with OVERFLOW=1, CARRY=0 (32767+1) → `STICKY_OVF`=1, `STICKY_CARRY`=0, `OVF_CNT`=1. Pulse `CLR_STATUS` alone → all 0. Pulse `CLR_STATUS` together with an overflow push → `STICKY_OVF`=1, `OVF_CNT`=1.
- Set `CNT_W`=2 and do 5 overflow pushes interleaved with pops → `OVF_CNT` saturates at 3.
- Push 3 entries, then drop `RST_N` asynchronously mid-cycle → immediately `COUNT`=0, `OUT_VALID`=0, sticky flags 0; after release, the first push reads back correctly.
